// File: rtl/scnn_sparse_compressor.sv
// scnn_sparse_compressor
//   Packs a dense activation tile (one DW-bit element per cycle) into
//   chunks of up to MAX_NZ non-zero values for the SCNN PE.
//   Each chunk carries the values, their dense indices relative to
//   offset_ipind, a raw count and a count padded to the PE's 4-wide fetch.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last   dense element stream
//   out_valid/out_ready       chunk handshake
//   compressed_inputs         packed non-zero values (slot 0 = first)
//   comp_indices_ips          per-slot dense index minus offset_ipind
//   num_nz_ips                count rounded up to a multiple of 4, min 4
//   num_nz_raw                true non-zero count
//   offset_ipind              dense index of the chunk's first element
//   out_last                  chunk closes the tile
//   err_overflow              sticky: tile ran past 256 elements
module scnn_sparse_compressor #(
  parameter int MAX_NZ = 16,
  parameter int DW     = 16,
  parameter int IW     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAX_NZ-1:0][DW-1:0]    compressed_inputs,
  output logic [MAX_NZ-1:0][IW-1:0]    comp_indices_ips,
  output logic [IW-1:0]                num_nz_ips,
  output logic [IW-1:0]                num_nz_raw,
  output logic [IW-1:0]                offset_ipind,
  output logic                         out_last,
  output logic                         err_overflow
);

  localparam int SW = $clog2(MAX_NZ);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                      state_q, state_d;
  logic [MAX_NZ-1:0][DW-1:0]   vals_q, vals_d;
  logic [MAX_NZ-1:0][IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]               nz_cnt_q, nz_cnt_d;
  logic [IW-1:0]               dense_idx_q, dense_idx_d;
  logic [IW-1:0]               chunk_base_q, chunk_base_d;
  logic                        last_q, last_d;
  logic                        err_q, err_d;

  logic                        accept;
  logic [SW-1:0]               slot;
  logic [IW-1:0]               rounded;

  assign in_ready = !rst && (state_q == FILL);
  assign accept   = in_valid && in_ready;
  // nz_cnt never reaches MAX_NZ while filling, so the low bits address the slot
  assign slot     = nz_cnt_q[SW-1:0];

  always_comb begin
    state_d      = state_q;
    vals_d       = vals_q;
    idx_d        = idx_q;
    nz_cnt_d     = nz_cnt_q;
    dense_idx_d  = dense_idx_q;
    chunk_base_d = chunk_base_q;
    last_d       = last_q;
    err_d        = err_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          dense_idx_d = dense_idx_q + IW'(1);
          if (dense_idx_q == '1 && !in_last) err_d = 1'b1;
          if (in_data != '0) begin
            vals_d[slot] = in_data;
            idx_d[slot]  = dense_idx_q - chunk_base_q;
            nz_cnt_d     = nz_cnt_q + IW'(1);
          end
          // A full chunk coinciding with in_last emits once, as the tile's last
          if (nz_cnt_d == IW'(MAX_NZ) || in_last) begin
            state_d = EMIT;
            last_d  = in_last;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          vals_d   = '0;
          idx_d    = '0;
          nz_cnt_d = '0;
          if (last_q) begin
            dense_idx_d  = '0;
            chunk_base_d = '0;
          end else begin
            chunk_base_d = dense_idx_q;
          end
          last_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      vals_q       <= '0;
      idx_q        <= '0;
      nz_cnt_q     <= '0;
      dense_idx_q  <= '0;
      chunk_base_q <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vals_q       <= vals_d;
      idx_q        <= idx_d;
      nz_cnt_q     <= nz_cnt_d;
      dense_idx_q  <= dense_idx_d;
      chunk_base_q <= chunk_base_d;
      last_q       <= last_d;
      err_q        <= err_d;
    end
  end

  assign rounded = (nz_cnt_q + IW'(3)) & ~IW'(3);

  assign out_valid         = (state_q == EMIT);
  assign compressed_inputs = vals_q;
  assign comp_indices_ips  = idx_q;
  assign num_nz_raw        = nz_cnt_q;
  assign num_nz_ips        = (nz_cnt_q == '0) ? IW'(4) : rounded;
  assign offset_ipind      = chunk_base_q;
  assign out_last          = last_q;
  assign err_overflow      = err_q;

endmodule

// File: tb/tb_scnn_sparse_compressor.sv
module tb_scnn_sparse_compressor;

  localparam int MAX_NZ = 16;
  localparam int DW     = 16;
  localparam int IW     = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic                        in_ready;
  logic [DW-1:0]               in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [MAX_NZ-1:0][DW-1:0]   compressed_inputs;
  logic [MAX_NZ-1:0][IW-1:0]   comp_indices_ips;
  logic [IW-1:0]               num_nz_ips;
  logic [IW-1:0]               num_nz_raw;
  logic [IW-1:0]               offset_ipind;
  logic                        out_last;
  logic                        err_overflow;

  int checks   = 0;
  int failures = 0;

  logic [MAX_NZ-1:0][DW-1:0]   ev;
  logic [MAX_NZ-1:0][IW-1:0]   ei;
  logic [MAX_NZ-1:0][DW-1:0]   held_v;

  always #5 clk = ~clk;

  scnn_sparse_compressor #(.MAX_NZ(MAX_NZ), .DW(DW), .IW(IW)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .compressed_inputs (compressed_inputs),
    .comp_indices_ips  (comp_indices_ips),
    .num_nz_ips        (num_nz_ips),
    .num_nz_raw        (num_nz_raw),
    .offset_ipind      (offset_ipind),
    .out_last          (out_last),
    .err_overflow      (err_overflow)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Time reference: every step starts 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 50 && !done; n++) begin
      if (in_ready) done = 1;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic chk_chunk(input string t,
                           input logic [MAX_NZ-1:0][DW-1:0] v,
                           input logic [MAX_NZ-1:0][IW-1:0] ix,
                           input logic [IW-1:0] raw, input logic [IW-1:0] ips,
                           input logic [IW-1:0] off, input logic lst);
    chk({t, ".valid"},  out_valid, 1);
    chk({t, ".vals"},   compressed_inputs, v);
    chk({t, ".idx"},    comp_indices_ips, ix);
    chk({t, ".raw"},    num_nz_raw, raw);
    chk({t, ".ips"},    num_nz_ips, ips);
    chk({t, ".off"},    offset_ipind, off);
    chk({t, ".last"},   out_last, lst);
    chk({t, ".inrdy"},  in_ready, 0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst.valid", out_valid, 0);
    chk("rst.inrdy", in_ready, 0);
    chk("rst.vals",  compressed_inputs, 0);
    chk("rst.raw",   num_nz_raw, 0);
    chk("rst.err",   err_overflow, 0);
    chk("rst.last",  out_last, 0);
    rst = 1'b0;
    #1;
    chk("rst.inrdy_after", in_ready, 1);

    // 1: sparse tile [0,5,0,0,7,0,0,0,3]
    out_ready = 1'b1;
    send(0, 0); send(5, 0); send(0, 0); send(0, 0); send(7, 0);
    send(0, 0); send(0, 0); send(0, 0);
    chk("t1.novalid_before_last", out_valid, 0);
    send(3, 1);
    ev = '0; ei = '0;
    ev[0] = 5; ev[1] = 7; ev[2] = 3;
    ei[0] = 1; ei[1] = 4; ei[2] = 8;
    chk_chunk("t1", ev, ei, 3, 4, 0, 1);
    step();
    chk("t1.valid_drop", out_valid, 0);
    chk("t1.inrdy_back", in_ready, 1);
    out_ready = 1'b0;

    // 2: 20 non-zeros 1..20 -> two chunks
    for (int i = 1; i <= 16; i++) send(DW'(i), 0);
    ev = '0; ei = '0;
    for (int i = 0; i < 16; i++) begin ev[i] = DW'(i + 1); ei[i] = IW'(i); end
    chk_chunk("t2a", ev, ei, 16, 16, 0, 0);
    handshake();
    chk("t2a.valid_drop", out_valid, 0);
    chk("t2a.inrdy_back", in_ready, 1);
    for (int i = 17; i <= 20; i++) send(DW'(i), i == 20);
    ev = '0; ei = '0;
    for (int i = 0; i < 4; i++) begin ev[i] = DW'(i + 17); ei[i] = IW'(i); end
    chk_chunk("t2b", ev, ei, 4, 4, 16, 1);
    handshake();

    // 3: exactly 16 non-zeros with in_last on the 16th
    for (int i = 0; i < 16; i++) send(DW'(16'h100 + i), i == 15);
    ev = '0; ei = '0;
    for (int i = 0; i < 16; i++) begin ev[i] = DW'(16'h100 + i); ei[i] = IW'(i); end
    chk_chunk("t3", ev, ei, 16, 16, 0, 1);
    handshake();
    step();
    chk("t3.no_second_chunk", out_valid, 0);

    // 4: all-zero tile
    send(0, 0); send(0, 0); send(0, 0); send(0, 1);
    chk_chunk("t4", '0, '0, 0, 4, 0, 1);
    handshake();

    // 5: hold with out_ready=0, then reset during EMIT
    send(0, 0); send(9, 0); send(2, 1);
    ev = '0; ei = '0;
    ev[0] = 9; ev[1] = 2; ei[0] = 1; ei[1] = 2;
    chk_chunk("t5", ev, ei, 2, 4, 0, 1);
    held_v = compressed_inputs;
    in_valid = 1'b1; in_data = 16'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5.hold_valid", out_valid, 1);
      chk("t5.hold_vals",  compressed_inputs, held_v);
      chk("t5.hold_raw",   num_nz_raw, 2);
      chk("t5.hold_inrdy", in_ready, 0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5.rst_valid", out_valid, 0);
    chk("t5.rst_inrdy", in_ready, 1);
    chk("t5.rst_raw",   num_nz_raw, 0);
    send(0, 0); send(0, 0); send(4, 1);
    ev = '0; ei = '0;
    ev[0] = 4; ei[0] = 2;
    chk_chunk("t5r", ev, ei, 1, 4, 0, 1);
    handshake();

    // 6: 257 elements without in_last -> overflow, index wrap
    for (int i = 0; i < 255; i++) send(0, 0);
    chk("t6.err_before", err_overflow, 0);
    send(0, 0);
    chk("t6.err_set", err_overflow, 1);
    send(0, 0);
    chk("t6.err_sticky", err_overflow, 1);
    send(3, 1);
    ev = '0; ei = '0;
    ev[0] = 3; ei[0] = 1;
    chk_chunk("t6", ev, ei, 1, 4, 0, 1);
    handshake();
    chk("t6.err_after_chunk", err_overflow, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t6.err_cleared", err_overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scnn_sparse_compressor.md
Name: scnn_sparse_compressor

Overview:
Upstream feeder for the SCNN processing element. Consumes a dense activation tile streamed one 16-bit element per cycle and packs the non-zero values into chunks of at most 16 entries. Each chunk carries its 8-bit position indices, a padded non-zero count and a base offset, and maps directly onto the PE's compressed_inputs, comp_indices_ips, num_nz_ips and offset_ipind inputs. Chunks are handed off with a valid/ready handshake.

Parameters:
MAX_NZ, 16, chunk capacity in non-zero entries (must be a multiple of 4).
DW, 16, data width.
IW, 8, index, count and offset width.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  dense element valid.
in_ready  out  1  block accepts an element this cycle.
in_data  in  DW  dense activation value.
in_last  in  1  final element of the tile.
out_valid  out  1  chunk available.
out_ready  in  1  downstream accepts the chunk.
compressed_inputs  out  MAX_NZ x DW  packed non-zero values; slot 0 holds the first non-zero.
comp_indices_ips  out  MAX_NZ x IW  dense index of each slot, relative to offset_ipind.
num_nz_ips  out  IW  non-zero count rounded up to a multiple of 4, minimum 4.
num_nz_raw  out  IW  true non-zero count, 0..MAX_NZ.
offset_ipind  out  IW  dense index of the chunk's first covered element.
out_last  out  1  chunk closes the tile.
err_overflow  out  1  sticky flag: tile exceeded 256 elements.

Behaviour:
- States: FILL and EMIT. Reset enters FILL.
- Reset values: out_valid=0, out_last=0, err_overflow=0, all value and index slots=0, nz_cnt=0, dense_idx=0, chunk_base=0.
- in_ready = !rst && state==FILL. It is combinational from state only, never from in_valid.
- Accept: in_valid && in_ready. Every accepted element increments dense_idx (IW bits, wraps 255 -> 0).
- Non-zero accepted element:
  - values[nz_cnt] <= in_data.
  - indices[nz_cnt] <= dense_idx - chunk_base (mod 256).
  - nz_cnt++.
- Zero elements only advance dense_idx.
- Emit trigger, evaluated on an accept: the element brings nz_cnt to MAX_NZ, or in_last=1. The next cycle the state is EMIT and out_valid=1. Latency from the triggering accept to out_valid is 1 cycle.
- out_last is set to the in_last of the triggering element. If the MAX_NZ-th non-zero and in_last arrive together, exactly one chunk is emitted, with out_last=1.
- While out_valid=1, every output is held stable until out_ready=1.
- Handshake (out_valid && out_ready):
  - All slots are zeroed and nz_cnt=0.
  - If out_last: dense_idx=0 and chunk_base=0. Otherwise chunk_base = dense_idx, the next unconsumed index.
  - Return to FILL; in_ready rises the following cycle.
  - out_ready while out_valid=0 is ignored.
- Padding: slots at or above nz_cnt are value 0 and index 0, so the PE's 4-wide fetch multiplies zeros harmlessly.
  - num_nz_ips = max(4, ceil4(nz_cnt)), e.g. 5 -> 8, 0 -> 4.
- Empty tile (in_last with no non-zeros): emit num_nz_raw=0, num_nz_ips=4, all slots zero, out_last=1.
- Overflow: accepting an element with dense_idx==255 and in_last=0 sets err_overflow. The element is still processed and indices wrap. err_overflow clears only on rst.
- A chunk that fills exactly at MAX_NZ with in_last=0 emits out_last=0. The tile continues in the next chunk, whose offset_ipind equals the index after the last consumed element.
- Reset mid-tile or mid-EMIT: all state is discarded next cycle and out_valid drops to 0. No partial chunk is ever emitted.
- Back-to-back tiles: the first element of the next tile is accepted the cycle after the last chunk's handshake.

Test Plan:
1. Tile of 9 elements [0,5,0,0,7,0,0,0,3], in_last on the 9th, out_ready=1 -> one chunk: values {5,7,3,0...}, indices {1,4,8,0...}, num_nz_raw=3, num_nz_ips=4, offset_ipind=0, out_last=1, out_valid 1 cycle after the last accept.
2. Tile of 20 non-zeros 1..20, in_last on the 20th -> chunk A: 1..16, indices 0..15, num_nz_ips=16, offset=0, out_last=0. Chunk B: 17..20, indices 0..3, offset=16, num_nz_raw=4, out_last=1. in_ready=0 during each EMIT.
3. Tile of 16 non-zeros with in_last on the 16th -> a single chunk with num_nz_raw=16 and out_last=1; no empty second chunk.
4. Tile of 4 zeros with in_last -> num_nz_raw=0, num_nz_ips=4, all slots zero, out_last=1.
5. Hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no input consumed. Assert rst during the hold -> next cycle out_valid=0, in_ready=1, and a following tile restarts at offset 0.
6. Stream 257 elements without in_last -> err_overflow=1 after the 256th accept and stays 1 until rst.
